rgb_fade_sequencer: RTL and testbench
=====================================

RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 SHALL have parameter LEVEL_W, default 8, meaning width of each channel level.
REQ-002 SHALL have parameter DIV_W, default 8, meaning width of step_div and hold_steps.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port mode_auto, input, 1: 1 = auto preset cycling, 0 = manual pass-through.
REQ-006 SHALL have port pause, input, 1: 1 = freeze all state, counters and outputs.
REQ-007 SHALL have ports manual_level0/1/2, input, LEVEL_W each: encoder-derived levels for R/G/B.
REQ-008 SHALL have port step_div, input, DIV_W: number of clocks per fade tick, minus 1.
REQ-009 SHALL have port hold_steps, input, DIV_W: ticks to dwell on a reached preset.
REQ-010 SHALL have ports level0/1/2, output, LEVEL_W each: registered duty levels to the PWM channels.
REQ-011 SHALL have port preset_idx, output, 2: current preset index.
REQ-012 SHALL have port at_target, output, 1: high while in HOLD.

Function
REQ-013 SHALL implement the FSM states MANUAL, FADE and HOLD.
REQ-014 In MANUAL, levelN SHALL equal manual_levelN registered, with 1-clock latency.
REQ-015 MANUAL with mode_auto=1 SHALL go to FADE on the next clock; target = PRESET[preset_idx]; levels start from their current values.
REQ-016 A tick SHALL assert when the prescaler equals step_div, and the prescaler SHALL then return to 0; step_div=0 gives a tick every clock.
REQ-017 The prescaler SHALL be held at 0 in MANUAL.
REQ-018 In FADE, on each tick, every channel SHALL move 1 LSB toward its target.
REQ-019 In FADE, a channel already at its target SHALL stay there; levels SHALL never overshoot or wrap.
REQ-020 When all three levels equal the target after an update, the FSM SHALL enter HOLD on that clock and load the hold counter with hold_steps.
REQ-021 In HOLD, the hold counter SHALL decrement on each tick.
REQ-022 In HOLD, a tick with the hold counter at 0 SHALL increment preset_idx (3 wraps to 0) and enter FADE toward the new preset.
REQ-023 hold_steps=0 SHALL mean leave HOLD on the first tick.
REQ-024 mode_auto=0 in any state SHALL force MANUAL on the next clock; preset_idx SHALL be retained, and manual values resume with 1-clock latency.
REQ-025 pause=1 SHALL hold state, prescaler, hold counter, preset_idx and levels; mode_auto changes while paused SHALL be ignored.
REQ-026 Simultaneous pause=1 and mode_auto=0: pause SHALL win.
REQ-027 A FADE whose target already equals the current levels SHALL enter HOLD on the first tick.
REQ-028 step_div or hold_steps changed mid-run SHALL take effect at the next compare or load; the prescaler SHALL NOT be reset.
REQ-029 The preset table SHALL be: 0 = (FF,00,00), 1 = (00,FF,00), 2 = (00,00,FF), 3 = (FF,FF,FF).

Reset
REQ-030 reset=1 SHALL, on the next clock, force state MANUAL, levels 0, preset_idx 0, prescaler 0, hold counter 0 and at_target 0.
REQ-031 reset SHALL override pause and mode_auto, including mid-FADE or mid-HOLD.
REQ-032 After reset is released, MANUAL pass-through SHALL be valid from the first following clock.

Structure
REQ-033 Package rgb_mixer_pkg SHALL hold the FSM state enum, LEVEL_W/DIV_W defaults, the preset table constant and NUM_PRESETS=4.
REQ-034 Sub-module rgb_tick_gen SHALL provide the prescaler, with inputs clk, reset, run and div, and output tick.
REQ-035 The FSM, hold counter and level steppers SHALL be in the top module.
REQ-036 The block SHALL connect between the encoder counters and the PWM channels of the RGB mixer.

Verification
REQ-037 Reset, then mode_auto=0 and manual=(10,20,30) -> levels=(10,20,30) one clock later; preset_idx=0.
REQ-038 From levels 0, step_div=0, hold_steps=2, mode_auto=1 -> level0 ramps 1/clock to FF, level1 and level2 stay 0; at_target rises 256 clocks after FADE entry; preset_idx becomes 1 three ticks later.
REQ-039 Run through preset 3 to HOLD end -> preset_idx wraps 3->0, and the fade to (FF,00,00) decrements G and B only.
REQ-040 step_div=3 -> level changes exactly every 4th clock; pause=1 for 10 clocks mid-fade -> no level change and no tick slip on release.
REQ-041 mode_auto dropped mid-FADE -> MANUAL next clock, levels = manual values; reasserting resumes FADE toward the same preset_idx.
REQ-042 reset asserted during HOLD with pause=1 -> all outputs 0, state MANUAL on the next clock.

Source files
------------

// File: rtl/rgb_mixer_pkg.sv
// Shared types and constants for the RGB mixer fade sequencer.
// Holds the FSM state enum, width defaults and the preset colour table.
package rgb_mixer_pkg;

   localparam int LEVEL_W_DEF = 8;
   localparam int DIV_W_DEF   = 8;
   localparam int NUM_PRESETS = 4;

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_FADE   = 2'd1,
      ST_HOLD   = 2'd2
   } fsm_state_t;

   // One bit per channel (bit0 = R, bit1 = G, bit2 = B).
   // A set bit means full scale, a clear bit means off.
   localparam logic [2:0] PRESET [NUM_PRESETS] = '{
      3'b001,
      3'b010,
      3'b100,
      3'b111
   };

endpackage

// File: rtl/rgb_tick_gen.sv
// Fade prescaler: tick pulses when the count equals div, then wraps to 0.
// Ports: clk, reset (sync, high), run (advance enable), div (clocks-1), tick.
module rgb_tick_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   assign tick = run && (cnt == div);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= tick ? '0 : cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Sits between the encoder counters and the PWM channels: passes manual
// levels through, or fades through the preset colours dwelling on each.
// Ports: clk, reset, mode_auto, pause, manual_level0..2, step_div,
//        hold_steps in; level0..2, preset_idx, at_target out.
module rgb_fade_sequencer
   import rgb_mixer_pkg::*;
#(
   parameter int LEVEL_W = LEVEL_W_DEF,
   parameter int DIV_W   = DIV_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mode_auto,
   input  logic               pause,
   input  logic [LEVEL_W-1:0] manual_level0,
   input  logic [LEVEL_W-1:0] manual_level1,
   input  logic [LEVEL_W-1:0] manual_level2,
   input  logic [DIV_W-1:0]   step_div,
   input  logic [DIV_W-1:0]   hold_steps,
   output logic [LEVEL_W-1:0] level0,
   output logic [LEVEL_W-1:0] level1,
   output logic [LEVEL_W-1:0] level2,
   output logic [1:0]         preset_idx,
   output logic               at_target
);

   fsm_state_t         state_q, state_d;
   logic [LEVEL_W-1:0] lvl_q [3];
   logic [LEVEL_W-1:0] lvl_d [3];
   logic [LEVEL_W-1:0] tgt   [3];
   logic [LEVEL_W-1:0] nxt   [3];
   logic [LEVEL_W-1:0] man   [3];
   logic [DIV_W-1:0]   hold_q, hold_d;
   logic [1:0]         idx_q, idx_d;
   logic               tick;
   logic               tick_run;
   logic               tick_clr;
   logic               all_eq;

   // Prescaler is parked at 0 while in MANUAL so a fade always starts
   // on a fresh prescaler period.
   assign tick_run = !pause && (state_q != ST_MANUAL);
   assign tick_clr = reset || (state_q == ST_MANUAL);

   rgb_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick (
      .clk   (clk),
      .reset (tick_clr),
      .run   (tick_run),
      .div   (step_div),
      .tick  (tick)
   );

   assign man[0] = manual_level0;
   assign man[1] = manual_level1;
   assign man[2] = manual_level2;

   always_comb begin
      all_eq = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tgt[c] = {LEVEL_W{PRESET[idx_q][c]}};
         if (lvl_q[c] < tgt[c]) begin
            nxt[c] = lvl_q[c] + LEVEL_W'(1);
         end else if (lvl_q[c] > tgt[c]) begin
            nxt[c] = lvl_q[c] - LEVEL_W'(1);
         end else begin
            nxt[c] = lvl_q[c];
         end
         if (nxt[c] != tgt[c]) begin
            all_eq = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      if (!pause) begin
         if (!mode_auto) begin
            state_d = ST_MANUAL;
            lvl_d   = man;
         end else begin
            case (state_q)
               ST_MANUAL: begin
                  state_d = ST_FADE;
               end
               ST_FADE: begin
                  if (tick) begin
                     lvl_d = nxt;
                     if (all_eq) begin
                        state_d = ST_HOLD;
                        hold_d  = hold_steps;
                     end
                  end
               end
               ST_HOLD: begin
                  if (tick) begin
                     if (hold_q == '0) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_FADE;
                     end else begin
                        hold_d = hold_q - DIV_W'(1);
                     end
                  end
               end
               default: begin
                  state_d = ST_MANUAL;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_MANUAL;
         hold_q  <= '0;
         idx_q   <= '0;
         for (int c = 0; c < 3; c++) begin
            lvl_q[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         lvl_q   <= lvl_d;
      end
   end

   assign level0     = lvl_q[0];
   assign level1     = lvl_q[1];
   assign level2     = lvl_q[2];
   assign preset_idx = idx_q;
   assign at_target  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_rgb_fade_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       mode_auto;
   logic       pause;
   logic [7:0] man0, man1, man2;
   logic [7:0] step_div;
   logic [7:0] hold_steps;
   logic [7:0] level0, level1, level2;
   logic [1:0] preset_idx;
   logic       at_target;

   int tests = 0;
   int fails = 0;

   // behavioural model: 0 = manual, 1 = fading, 2 = dwelling
   int m_mode;
   int m_pre;
   int m_hold;
   int m_idx;
   int m_lvl [3];

   always #5 clk = ~clk;

   rgb_fade_sequencer #(
      .LEVEL_W (8),
      .DIV_W   (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mode_auto     (mode_auto),
      .pause         (pause),
      .manual_level0 (man0),
      .manual_level1 (man1),
      .manual_level2 (man2),
      .step_div      (step_div),
      .hold_steps    (hold_steps),
      .level0        (level0),
      .level1        (level1),
      .level2        (level2),
      .preset_idx    (preset_idx),
      .at_target     (at_target)
   );

   function automatic int target_of(int idx, int ch);
      return (idx == 3 || idx == ch) ? 255 : 0;
   endfunction

   task automatic model_step();
      int  mv [3];
      bit  tk;
      bit  done;
      mv[0] = man0;
      mv[1] = man1;
      mv[2] = man2;
      if (reset) begin
         m_mode = 0; m_pre = 0; m_hold = 0; m_idx = 0;
         for (int c = 0; c < 3; c++) m_lvl[c] = 0;
      end else if (!pause) begin
         if (!mode_auto) begin
            m_mode = 0;
            m_pre  = 0;
            for (int c = 0; c < 3; c++) m_lvl[c] = mv[c];
         end else if (m_mode == 0) begin
            m_mode = 1;
            m_pre  = 0;
         end else begin
            tk    = (m_pre == int'(step_div));
            m_pre = tk ? 0 : (m_pre + 1) % 256;
            if (tk && m_mode == 1) begin
               done = 1'b1;
               for (int c = 0; c < 3; c++) begin
                  if (m_lvl[c] < target_of(m_idx, c)) m_lvl[c]++;
                  else if (m_lvl[c] > target_of(m_idx, c)) m_lvl[c]--;
                  if (m_lvl[c] != target_of(m_idx, c)) done = 1'b0;
               end
               if (done) begin
                  m_mode = 2;
                  m_hold = hold_steps;
               end
            end else if (tk && m_mode == 2) begin
               if (m_hold == 0) begin
                  m_idx  = (m_idx + 1) % 4;
                  m_mode = 1;
               end else begin
                  m_hold--;
               end
            end
         end
      end
   endtask

   task automatic clk_edge();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; mode_auto = 1'b0; pause = 1'b0;
      man0 = 8'd0; man1 = 8'd0; man2 = 8'd0;
      clk_edge();
      reset = 1'b0;
      clk_edge();
   endtask

   task automatic test_reset();
      reset = 1'b1; mode_auto = 1'b1; pause = 1'b1;
      man0 = 8'h5a; man1 = 8'ha5; man2 = 8'h3c;
      clk_edge();
      tests++;
      if ({level0, level1, level2, preset_idx, at_target} !== 27'd0) begin
         fails++;
         $display("FAIL reset: got %h %h %h idx=%0d at=%b, want all 0",
                  level0, level1, level2, preset_idx, at_target);
      end
      reset = 1'b0; pause = 1'b0; mode_auto = 1'b0;
   endtask

   task automatic test_manual();
      do_reset();
      man0 = 8'd10; man1 = 8'd20; man2 = 8'd30;
      tests++;
      if ({level0, level1, level2} !== 24'd0) begin
         fails++;
         $display("FAIL manual_latency: got %0d %0d %0d before edge, want 0",
                  level0, level1, level2);
      end
      clk_edge();
      tests++;
      if (level0 !== 8'd10 || level1 !== 8'd20 || level2 !== 8'd30 ||
          preset_idx !== 2'd0) begin
         fails++;
         $display("FAIL manual: got %0d %0d %0d idx=%0d, want 10 20 30 idx=0",
                  level0, level1, level2, preset_idx);
      end
   endtask

   task automatic test_fade_ramp();
      logic [7:0] e0;
      do_reset();
      step_div = 8'd0; hold_steps = 8'd2;
      mode_auto = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         clk_edge();
         e0 = 8'(k - 1);
         tests++;
         if (level0 !== e0 || level1 !== 8'd0 || level2 !== 8'd0 ||
             at_target !== (k == 256)) begin
            fails++;
            $display("FAIL ramp k=%0d: got %h %h %h at=%b, want %h 00 00 at=%b",
                     k, level0, level1, level2, at_target, e0, (k == 256));
         end
      end
      for (int k = 1; k <= 3; k++) begin
         clk_edge();
         tests++;
         if (preset_idx !== ((k == 3) ? 2'd1 : 2'd0) ||
             at_target !== (k < 3)) begin
            fails++;
            $display("FAIL hold_exit k=%0d: idx=%0d at=%b, want idx=%0d at=%b",
                     k, preset_idx, at_target, (k == 3) ? 1 : 0, (k < 3));
         end
      end
   endtask

   task automatic test_wrap();
      int  n;
      bit  seen;
      logic [7:0] e;
      step_div = 8'd0; hold_steps = 8'd0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 3000) begin
         clk_edge();
         n++;
         seen = (preset_idx == 2'd3) && at_target;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL wrap_reach: got idx=%0d at=%b, want idx=3 in HOLD",
                  preset_idx, at_target);
      end
      clk_edge();
      tests++;
      if (preset_idx !== 2'd0 || at_target !== 1'b0 ||
          {level0, level1, level2} !== 24'hffffff) begin
         fails++;
         $display("FAIL wrap: got idx=%0d at=%b %h %h %h, want idx=0 at=0 ff ff ff",
                  preset_idx, at_target, level0, level1, level2);
      end
      for (int k = 1; k <= 8; k++) begin
         clk_edge();
         e = 8'(255 - k);
         tests++;
         if (level0 !== 8'hff || level1 !== e || level2 !== e) begin
            fails++;
            $display("FAIL wrap_fade k=%0d: got %h %h %h, want ff %h %h",
                     k, level0, level1, level2, e, e);
         end
      end
   endtask

   task automatic test_div_pause();
      int f;
      logic [7:0] e;
      do_reset();
      step_div = 8'd3; hold_steps = 8'd0;
      mode_auto = 1'b1;
      clk_edge();
      f = 0;
      for (int n = 2; n <= 41; n++) begin
         pause = (n >= 22 && n <= 31);
         clk_edge();
         if (!pause) f++;
         e = 8'(f / 4);
         tests++;
         if (level0 !== e || level1 !== 8'd0 || level2 !== 8'd0 ||
             preset_idx !== 2'd0 || at_target !== 1'b0) begin
            fails++;
            $display("FAIL div_pause n=%0d: got %h %h %h idx=%0d, want %h 00 00 idx=0",
                     n, level0, level1, level2, preset_idx, e);
         end
      end
      pause = 1'b0;
   endtask

   task automatic test_override();
      int n;
      do_reset();
      step_div = 8'd0; hold_steps = 8'd0;
      mode_auto = 1'b1;
      n = 0;
      while (preset_idx != 2'd1 && n < 400) begin
         clk_edge();
         n++;
      end
      repeat (10) clk_edge();
      man0 = 8'h33; man1 = 8'h44; man2 = 8'h55;
      mode_auto = 1'b0;
      clk_edge();
      tests++;
      if (level0 !== 8'h33 || level1 !== 8'h44 || level2 !== 8'h55 ||
          preset_idx !== 2'd1 || at_target !== 1'b0) begin
         fails++;
         $display("FAIL override: got %h %h %h idx=%0d, want 33 44 55 idx=1",
                  level0, level1, level2, preset_idx);
      end
      mode_auto = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         clk_edge();
         tests++;
         if (level0 !== 8'(8'h33 - k) || level1 !== 8'(8'h44 + k) ||
             level2 !== 8'(8'h55 - k) || preset_idx !== 2'd1) begin
            fails++;
            $display("FAIL resume k=%0d: got %h %h %h idx=%0d, want %h %h %h idx=1",
                     k, level0, level1, level2, preset_idx,
                     8'(8'h33 - k), 8'(8'h44 + k), 8'(8'h55 - k));
         end
      end
   endtask

   task automatic test_reset_hold();
      int n;
      do_reset();
      step_div = 8'd0; hold_steps = 8'd200;
      mode_auto = 1'b1;
      n = 0;
      while (!at_target && n < 400) begin
         clk_edge();
         n++;
      end
      repeat (3) clk_edge();
      tests++;
      if (at_target !== 1'b1) begin
         fails++;
         $display("FAIL hold_reach: got at=%b, want 1", at_target);
      end
      pause = 1'b1; reset = 1'b1;
      clk_edge();
      tests++;
      if ({level0, level1, level2, preset_idx, at_target} !== 27'd0) begin
         fails++;
         $display("FAIL reset_hold: got %h %h %h idx=%0d at=%b, want all 0",
                  level0, level1, level2, preset_idx, at_target);
      end
      reset = 1'b0; pause = 1'b0; mode_auto = 1'b0;
      man0 = 8'd1; man1 = 8'd2; man2 = 8'd3;
      clk_edge();
      tests++;
      if (level0 !== 8'd1 || level1 !== 8'd2 || level2 !== 8'd3) begin
         fails++;
         $display("FAIL post_reset: got %0d %0d %0d, want 1 2 3",
                  level0, level1, level2);
      end
   endtask

   task automatic test_random();
      do_reset();
      step_div = 8'd1; hold_steps = 8'd1;
      mode_auto = 1'b1;
      for (int i = 0; i < 30000; i++) begin
         if ($urandom_range(499) == 0) mode_auto = ~mode_auto;
         if ($urandom_range(199) == 0) step_div = 8'($urandom_range(2));
         if ($urandom_range(199) == 0) hold_steps = 8'($urandom_range(3));
         if ($urandom_range(99) == 0) begin
            man0 = 8'($urandom); man1 = 8'($urandom); man2 = 8'($urandom);
         end
         pause = ($urandom_range(19) == 0);
         reset = ($urandom_range(4999) == 0);
         clk_edge();
         tests++;
         if (level0 !== 8'(m_lvl[0]) || level1 !== 8'(m_lvl[1]) ||
             level2 !== 8'(m_lvl[2]) || preset_idx !== 2'(m_idx) ||
             at_target !== (m_mode == 2)) begin
            fails++;
            $display("FAIL random i=%0d: got %h %h %h idx=%0d at=%b, want %h %h %h idx=%0d at=%b",
                     i, level0, level1, level2, preset_idx, at_target,
                     8'(m_lvl[0]), 8'(m_lvl[1]), 8'(m_lvl[2]), m_idx, (m_mode == 2));
         end
      end
      reset = 1'b0; pause = 1'b0;
   endtask

   initial begin
      reset = 1'b1; mode_auto = 1'b0; pause = 1'b0;
      man0 = 8'd0; man1 = 8'd0; man2 = 8'd0;
      step_div = 8'd0; hold_steps = 8'd0;
      m_mode = 0; m_pre = 0; m_hold = 0; m_idx = 0;
      for (int c = 0; c < 3; c++) m_lvl[c] = 0;
      test_reset();
      test_manual();
      test_fade_ramp();
      test_wrap();
      test_div_pause();
      test_override();
      test_reset_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
